// File: rtl/fp_mult_pkg.sv
// Shared definitions for the minifloat multiplier datapath.
// Word layout is {sign, exp, man}; flags are carried as a small bit vector.
package fp_mult_pkg;

   localparam int FLAG_OVF = 0;
   localparam int FLAG_UNF = 1;
   localparam int FLAG_W   = 2;

   localparam bit RND_TRUNC = 1'b0;
   localparam bit RND_RNE   = 1'b1;

   function automatic int fp_width(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round, carry-renormalise, saturate/flush and pack a normalised minifloat; combinational.
// No flow control of its own: the instantiating pipeline registers the outputs.
module fp_round_pack
   import fp_mult_pkg::*;
#(
   parameter int EXP_W     = 3,
   parameter int MAN_W     = 4,
   parameter bit ROUND_RNE = RND_RNE,
   localparam int W        = fp_width(EXP_W, MAN_W)
) (
   input  logic                    sign_i,
   input  logic                    zero_i,
   input  logic signed [EXP_W+1:0] exp_i,
   input  logic [MAN_W-1:0]        man_i,
   input  logic                    guard_i,
   input  logic                    sticky_i,
   output logic [W-1:0]            word_o,
   output logic [FLAG_W-1:0]       flags_o
);

   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_MIN = EW'(1);

   logic                 round_up;
   logic [MAN_W:0]       man_sum;
   logic signed [EW-1:0] exp_r;

   always_comb begin
      round_up = (ROUND_RNE == RND_RNE) && guard_i && (sticky_i || man_i[0]);
      man_sum  = {1'b0, man_i} + {{MAN_W{1'b0}}, round_up};
      // An all-ones mantissa rolling over leaves man_sum[MAN_W-1:0] at zero already.
      exp_r    = exp_i + $signed(EW'(man_sum[MAN_W]));

      word_o   = {sign_i, {(EXP_W + MAN_W){1'b0}}};
      flags_o  = '0;
      if (!zero_i) begin
         if (exp_r > EXP_MAX) begin
            word_o            = {sign_i, {(EXP_W + MAN_W){1'b1}}};
            flags_o[FLAG_OVF] = 1'b1;
         end else if (exp_r < EXP_MIN) begin
            flags_o[FLAG_UNF] = 1'b1;
         end else begin
            word_o = {sign_i, exp_r[EXP_W-1:0], man_sum[MAN_W-1:0]};
         end
      end
   end

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined minifloat multiplier with ovf/unf flags; 3 cycles handshake-to-out_valid, 1/cycle.
// Whole pipe freezes (bubbles included) while out_valid is held by a low out_ready.
module fp_mult_pipe
   import fp_mult_pkg::*;
#(
   parameter int EXP_W     = 3,
   parameter int MAN_W     = 4,
   parameter int BIAS      = 3,
   parameter bit ROUND_RNE = RND_RNE,
   localparam int W        = fp_width(EXP_W, MAN_W)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_p,
   output logic         out_ovf,
   output logic         out_unf
);

   localparam int PW = 2 * MAN_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);

   logic advance;

   logic                 v1_q, v1_d, s1_q, s1_d, z1_q, z1_d;
   logic [PW-1:0]        p1_q, p1_d;
   logic signed [EW-1:0] e1_q, e1_d;

   logic                 v2_q, v2_d, s2_q, s2_d, z2_q, z2_d;
   logic [MAN_W-1:0]     m2_q, m2_d;
   logic                 g2_q, g2_d, st2_q, st2_d;
   logic signed [EW-1:0] e2_q, e2_d;
   logic                 norm;

   logic [W-1:0]         pk_word;
   logic [FLAG_W-1:0]    pk_flags;
   logic                 out_valid_q, out_valid_d;
   logic [W-1:0]         out_p_q, out_p_d;
   logic                 out_ovf_q, out_ovf_d, out_unf_q, out_unf_d;

   assign advance   = !out_valid_q || out_ready;
   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign out_p     = out_p_q;
   assign out_ovf   = out_ovf_q;
   assign out_unf   = out_unf_q;

   // S1: unpack, zero detect, multiply, raw exponent sum
   always_comb begin
      v1_d = in_valid;
      s1_d = in_a[W-1] ^ in_b[W-1];
      z1_d = (in_a[W-2 -: EXP_W] == '0) || (in_b[W-2 -: EXP_W] == '0);
      p1_d = PW'({1'b1, in_a[MAN_W-1:0]}) * PW'({1'b1, in_b[MAN_W-1:0]});
      e1_d = $signed(EW'(in_a[W-2 -: EXP_W])) + $signed(EW'(in_b[W-2 -: EXP_W])) - BIAS_S;
   end

   // S2: product is in [1,4); pick the leading one and split off guard/sticky
   always_comb begin
      v2_d = v1_q;
      s2_d = s1_q;
      z2_d = z1_q;
      norm = p1_q[PW-1];
      if (norm) begin
         m2_d  = p1_q[PW-2 -: MAN_W];
         g2_d  = p1_q[MAN_W];
         st2_d = |p1_q[MAN_W-1:0];
      end else begin
         m2_d  = p1_q[PW-3 -: MAN_W];
         g2_d  = p1_q[MAN_W-1];
         st2_d = |p1_q[MAN_W-2:0];
      end
      e2_d = e1_q + $signed(EW'(norm));
   end

   fp_round_pack #(
      .EXP_W     (EXP_W),
      .MAN_W     (MAN_W),
      .ROUND_RNE (ROUND_RNE)
   ) u_round_pack (
      .sign_i   (s2_q),
      .zero_i   (z2_q),
      .exp_i    (e2_q),
      .man_i    (m2_q),
      .guard_i  (g2_q),
      .sticky_i (st2_q),
      .word_o   (pk_word),
      .flags_o  (pk_flags)
   );

   always_comb begin
      out_valid_d = v2_q;
      out_p_d     = pk_word;
      out_ovf_d   = pk_flags[FLAG_OVF];
      out_unf_d   = pk_flags[FLAG_UNF];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         s1_q        <= 1'b0;
         z1_q        <= 1'b0;
         p1_q        <= '0;
         e1_q        <= '0;
         v2_q        <= 1'b0;
         s2_q        <= 1'b0;
         z2_q        <= 1'b0;
         m2_q        <= '0;
         g2_q        <= 1'b0;
         st2_q       <= 1'b0;
         e2_q        <= '0;
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
         out_ovf_q   <= 1'b0;
         out_unf_q   <= 1'b0;
      end else if (advance) begin
         v1_q        <= v1_d;
         s1_q        <= s1_d;
         z1_q        <= z1_d;
         p1_q        <= p1_d;
         e1_q        <= e1_d;
         v2_q        <= v2_d;
         s2_q        <= s2_d;
         z2_q        <= z2_d;
         m2_q        <= m2_d;
         g2_q        <= g2_d;
         st2_q       <= st2_d;
         e2_q        <= e2_d;
         out_valid_q <= out_valid_d;
         out_p_q     <= out_p_d;
         out_ovf_q   <= out_ovf_d;
         out_unf_q   <= out_unf_d;
      end
   end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe at default parameters, with a truncating twin instance.
module tb_fp_mult_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;

   logic         in_ready, out_valid, out_ovf, out_unf;
   logic [W-1:0] out_p;
   logic         t_in_ready, t_out_valid, t_out_ovf, t_out_unf;
   logic [W-1:0] t_out_p;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fp_mult_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .out_ovf   (out_ovf),
      .out_unf   (out_unf)
   );

   fp_mult_pipe #(.ROUND_RNE(1'b0)) dut_trunc (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (t_in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (t_out_valid),
      .out_ready (out_ready),
      .out_p     (t_out_p),
      .out_ovf   (t_out_ovf),
      .out_unf   (t_out_unf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One isolated operand pair: checks the 3-cycle latency and both rounding modes.
   task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] p_rne, input logic [7:0] p_trn,
                          input logic ovf, input logic unf);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      #1;
      check({tag, "/in_ready"}, 32'(in_ready), 1);
      step();
      in_valid = 1'b0;
      check({tag, "/valid_c1"}, 32'(out_valid), 0);
      step();
      check({tag, "/valid_c2"}, 32'(out_valid), 0);
      step();
      check({tag, "/valid_c3"}, 32'(out_valid), 1);
      check({tag, "/p"}, 32'(out_p), 32'(p_rne));
      check({tag, "/ovf"}, 32'(out_ovf), 32'(ovf));
      check({tag, "/unf"}, 32'(out_unf), 32'(unf));
      check({tag, "/trunc_valid"}, 32'(t_out_valid), 1);
      check({tag, "/trunc_p"}, 32'(t_out_p), 32'(p_trn));
      check({tag, "/trunc_ovf"}, 32'(t_out_ovf), 32'(ovf));
      check({tag, "/trunc_unf"}, 32'(t_out_unf), 32'(unf));
      step();
   endtask

   logic [7:0] sa [6] = '{8'h38, 8'hC0, 8'h38, 8'h7F, 8'h10, 8'h90};
   logic [7:0] sb [6] = '{8'h38, 8'h48, 8'h35, 8'h7F, 8'h10, 8'h10};
   logic [7:0] sp [6] = '{8'h42, 8'hD8, 8'h40, 8'h7F, 8'h00, 8'h80};
   logic       so [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic       su [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int nacc;
      int ndel;

      // Reset state
      step();
      step();
      check("rst/out_valid", 32'(out_valid), 0);
      check("rst/out_p", 32'(out_p), 0);
      check("rst/out_ovf", 32'(out_ovf), 0);
      check("rst/out_unf", 32'(out_unf), 0);
      rst_n = 1'b1;
      #1;
      check("rst/in_ready_after_release", 32'(in_ready), 1);
      check("rst/trunc_in_ready", 32'(t_in_ready), 1);
      step();

      // Directed vectors: tag, a, b, RNE product, truncated product, ovf, unf
      run_vec("basic",      8'h38, 8'h38, 8'h42, 8'h42, 1'b0, 1'b0);
      run_vec("signed",     8'hC0, 8'h48, 8'hD8, 8'hD8, 1'b0, 1'b0);
      run_vec("rnd_carry",  8'h38, 8'h35, 8'h40, 8'h3F, 1'b0, 1'b0);
      run_vec("rnd_tie_ev", 8'h33, 8'h38, 8'h3C, 8'h3C, 1'b0, 1'b0);
      run_vec("ovf",        8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0);
      run_vec("unf",        8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 1'b1);
      run_vec("unf_neg",    8'h90, 8'h10, 8'h80, 8'h80, 1'b0, 1'b1);
      run_vec("exp_max",    8'h60, 8'h40, 8'h70, 8'h70, 1'b0, 1'b0);
      run_vec("exp_min",    8'h10, 8'h30, 8'h10, 8'h10, 1'b0, 1'b0);
      run_vec("zero_neg",   8'h00, 8'hC8, 8'h80, 8'h80, 1'b0, 1'b0);
      run_vec("zero_man",   8'h05, 8'h38, 8'h00, 8'h00, 1'b0, 1'b0);

      // Backpressure: 6 back-to-back pairs, out_ready low in cycles 4..7
      nacc = 0;
      ndel = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         out_ready = !(cyc >= 4 && cyc <= 7);
         in_valid  = (nacc < 6);
         if (nacc < 6) begin
            in_a = sa[nacc];
            in_b = sb[nacc];
         end
         #1;
         if (cyc >= 4 && cyc <= 7) begin
            check("bp/in_ready_stall", 32'(in_ready), 0);
            check("bp/valid_stall", 32'(out_valid), 1);
            check("bp/p_held", 32'(out_p), 32'(sp[ndel]));
         end
         if (out_valid && out_ready) begin
            if (ndel < 6) begin
               check("bp/order_p", 32'(out_p), 32'(sp[ndel]));
               check("bp/order_ovf", 32'(out_ovf), 32'(so[ndel]));
               check("bp/order_unf", 32'(out_unf), 32'(su[ndel]));
            end else begin
               check("bp/extra_product", 32'(out_valid), 0);
            end
            ndel++;
         end
         if (in_valid && in_ready) nacc++;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp/accepted", 32'(nacc), 6);
      check("bp/delivered", 32'(ndel), 6);

      // Reset with three products in flight
      for (int i = 0; i < 3; i++) begin
         in_a     = sa[i];
         in_b     = sb[i];
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      check("mid_rst/pre_valid", 32'(out_valid), 1);
      check("mid_rst/pre_p", 32'(out_p), 32'(sp[0]));
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst/valid_drop", 32'(out_valid), 0);
      check("mid_rst/p_clear", 32'(out_p), 0);
      step();
      step();
      rst_n = 1'b1;
      #1;
      check("mid_rst/in_ready", 32'(in_ready), 1);
      for (int i = 0; i < 6; i++) begin
         step();
         check("mid_rst/no_stale", 32'(out_valid), 0);
      end
      run_vec("post_rst",   8'h38, 8'h48, 8'h52, 8'h52, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
